// File: rtl/hyperbus_ck_seq_if.sv
// hyperbus_ck_seq_if
//   Request/response and pad-control signals between the HyperBus transaction
//   FSM (master side) and the CK/CS# sequencer (slave side).
//
//   Handshake: a request transfers on a rising clock edge where
//   start_valid_i && start_ready_o. Once valid is raised, the master holds
//   start_valid_i and num_ck_i stable until that edge. start_ready_o does not
//   depend on start_valid_i.
//
//   Signals:
//     start_valid_i  master->slave  transaction request
//     start_ready_o  slave->master  sequencer idle, request accepted when valid&ready
//     num_ck_i       master->slave  CK cycles to emit, sampled at handshake
//     abort_i        master->slave  terminate burst early
//     cs_no          slave->pad     chip select, active-low
//     ck_en_o        slave->phy     enable for CK gating cell
//     busy_o         slave->master  transaction in progress
//     done_o         slave->master  one-cycle pulse, transaction finished
//     aborted_o      slave->master  qualifies done_o: ended by abort_i
interface hyperbus_ck_seq_if #(
  parameter int CNT_W = 16
);
  logic             start_valid_i;
  logic             start_ready_o;
  logic [CNT_W-1:0] num_ck_i;
  logic             abort_i;
  logic             cs_no;
  logic             ck_en_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;

  modport master (
    output start_valid_i, num_ck_i, abort_i,
    input  start_ready_o, cs_no, ck_en_o, busy_o, done_o, aborted_o
  );

  modport slave (
    input  start_valid_i, num_ck_i, abort_i,
    output start_ready_o, cs_no, ck_en_o, busy_o, done_o, aborted_o
  );
endinterface

// File: rtl/hyperbus_ck_seq.sv
// hyperbus_ck_seq
//   Sequences CS# and the CK gating enable for one HyperBus transaction:
//   CS# setup before the first CK, an exact CK burst, CK-to-CS# hold and a
//   minimum CS# high (recovery) time before the next request is accepted.
//
//   Ports:
//     clk_i        clock, same clock as the CK gating stage
//     rst_i        synchronous reset, active-high
//     bus          slave modport of hyperbus_ck_seq_if (handshake + pad controls)
//     dbg_state_o  current FSM state (IDLE=0 SETUP=1 ACTIVE=2 HOLD=3 RECOVER=4)
//
//   All outputs are decoded from flops, so there is no input-to-output
//   combinational path and ck_en_o only moves on the rising edge of clk_i,
//   which keeps the downstream low-transparent gating latch glitch-free.
module hyperbus_ck_seq #(
  parameter int CSS_CYCLES  = 2,
  parameter int CSH_CYCLES  = 2,
  parameter int CSHI_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hyperbus_ck_seq_if.slave  bus,
  output logic [2:0]        dbg_state_o
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (CSS_CYCLES < 1 || longint'(CSS_CYCLES) > CNT_LIM ||
      CSH_CYCLES < 1 || longint'(CSH_CYCLES) > CNT_LIM ||
      CSHI_CYCLES < 1 || longint'(CSHI_CYCLES) > CNT_LIM) begin : g_param_err
    $error("hyperbus_ck_seq: *_CYCLES must be in 1..2**CNT_W");
  end

  // Counter load values: a state lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] CSS_LD  = CNT_W'(CSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CSH_LD  = CNT_W'(CSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CSHI_LD = CNT_W'(CSHI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_ck_q, num_ck_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      num_ck_q <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_ck_q <= num_ck_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    // Saturating down-count; every state transition below overrides this.
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    num_ck_d = num_ck_q;
    abort_d  = abort_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort_i is deliberately ignored here, even alongside a handshake.
        if (bus.start_valid_i) begin
          state_d  = S_SETUP;
          cnt_d    = CSS_LD;
          num_ck_d = bus.num_ck_i;
          abort_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (bus.abort_i) begin
          state_d = S_HOLD;
          cnt_d   = CSH_LD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (num_ck_q != '0) begin
            state_d = S_ACTIVE;
            cnt_d   = num_ck_q - CNT_W'(1);
          end else begin
            // Zero-length burst: CS# pulse with no CK at all.
            state_d = S_HOLD;
            cnt_d   = CSH_LD;
          end
        end
      end
      S_ACTIVE: begin
        if (bus.abort_i) begin
          state_d = S_HOLD;
          cnt_d   = CSH_LD;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CSH_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RECOVER;
          cnt_d   = CSHI_LD;
          done_d  = 1'b1;   // lands in the first RECOVER cycle
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.start_ready_o = (state_q == S_IDLE);
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.cs_no         = !((state_q == S_SETUP) || (state_q == S_ACTIVE) ||
                               (state_q == S_HOLD));
  assign bus.ck_en_o       = (state_q == S_ACTIVE);
  assign bus.done_o        = done_q;
  assign bus.aborted_o     = done_q & abort_q;
  assign dbg_state_o       = state_q;

endmodule
